// File: rtl/uart_if.sv
// Byte-side and serial-side signals of the 8N1 UART.
// The slave modport is the UART itself; master is the user logic.
interface uart_if;
    logic       Rx;
    logic [7:0] data;
    logic       send_data;
    logic       Tx;
    logic       TiP;
    logic       NrD;
    logic [7:0] O_DATA;
    logic       ctrl;

    modport slave (
        input  Rx, data, send_data,
        output Tx, TiP, NrD, O_DATA, ctrl
    );

    modport master (
        output Rx, data, send_data,
        input  Tx, TiP, NrD, O_DATA, ctrl
    );
endinterface

// File: rtl/uart.sv
// Full-duplex 8N1 UART: independent TX and RX engines sharing one
// baud divider; RX input passes through a two-flop synchroniser.
module uart #(
    parameter int BAUD_DIVIDER = 104
) (
    input logic   clk,
    input logic   rst,
    uart_if.slave bus
);
    localparam int CW = (BAUD_DIVIDER < 2) ? 1 : $clog2(BAUD_DIVIDER);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIVIDER - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIVIDER / 2);

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE
    } rx_state_e;

    tx_state_e       tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_q;
    logic            tip_q;

    rx_state_e       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            nrd_q;
    logic [7:0]      odata_q;
    logic            ctrl_q;

    assign bus.Tx     = tx_q;
    assign bus.TiP    = tip_q;
    assign bus.NrD    = nrd_q;
    assign bus.O_DATA = odata_q;
    assign bus.ctrl   = ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            tip_q      <= 1'b0;
        end else begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (bus.send_data) begin
                        tx_sh_q    <= bus.data;
                        tx_q       <= 1'b0;
                        tip_q      <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_sh_q[0];
                        tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_bit_q <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == LAST) begin
                        tx_cnt_q   <= '0;
                        tip_q      <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            nrd_q      <= 1'b0;
            odata_q    <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            sync1_q <= bus.Rx;
            sync2_q <= sync1_q;
            nrd_q   <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        ctrl_q   <= 1'b1;
                        rx_bit_q <= '0;
                        // With no half-bit delay the start bit is confirmed now.
                        if (BAUD_DIVIDER / 2 == 0) begin
                            rx_cnt_q   <= '0;
                            rx_state_q <= RX_DATA;
                        end else begin
                            rx_cnt_q   <= CW'(1);
                            rx_state_q <= RX_START;
                        end
                    end
                end
                RX_START: begin
                    if (rx_cnt_q >= HALF) begin
                        rx_cnt_q <= '0;
                        if (sync2_q) begin
                            ctrl_q     <= 1'b0;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {sync2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_q <= '0;
                        if (sync2_q) begin
                            odata_q    <= rx_sh_q;
                            nrd_q      <= 1'b1;
                            ctrl_q     <= 1'b0;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_WAIT_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (sync2_q) begin
                        ctrl_q     <= 1'b0;
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart.sv
// Bench for uart: three instances (divider 1, 4 looped back, 8 driven)
// checked with a frame table, hand sequences and a byte-queue model.
module tb_uart;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_if b1 ();
    uart_if b4 ();
    uart_if b8 ();

    assign b1.Rx = b1.Tx;
    assign b4.Rx = b4.Tx;

    uart #(.BAUD_DIVIDER(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    uart #(.BAUD_DIVIDER(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    uart #(.BAUD_DIVIDER(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int nrd8  = 0;
    logic [7:0] q1[$];
    logic [7:0] q4[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every byte sent on a looped port must come back exactly once, in order.
    always @(negedge clk) begin
        if (!rst && b1.NrD === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u1 unexpected NrD: got %0h expected none", b1.O_DATA);
            end else check("u1 rx byte", b1.O_DATA, q1.pop_front());
        end
        if (!rst && b4.NrD === 1'b1) begin
            if (q4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u4 unexpected NrD: got %0h expected none", b4.O_DATA);
            end else check("u4 rx byte", b4.O_DATA, q4.pop_front());
        end
        if (!rst && b8.NrD === 1'b1) nrd8++;
    end

    task automatic drive8(input logic [7:0] d, input logic stopv);
        b8.Rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            b8.Rx = d[b];
            repeat (8) @(negedge clk);
        end
        b8.Rx = stopv;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[4];
        logic [9:0] f;
        logic [7:0] d;
        int tip_cnt, base;
        bit got, seen;

        tbl[0] = '{8'h55, 10'b1010101010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'hA3, 10'b1101000110};

        rst = 1'b1;
        b1.data = '0; b1.send_data = 1'b0;
        b4.data = '0; b4.send_data = 1'b0;
        b8.data = '0; b8.send_data = 1'b0;
        b8.Rx = 1'b1;
        #3;
        check("reset Tx", b4.Tx, 1);
        check("reset TiP", b4.TiP, 0);
        check("reset NrD", b4.NrD, 0);
        check("reset O_DATA", b4.O_DATA, 0);
        check("reset ctrl", b4.ctrl, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Divider 1: frame bits on consecutive clocks
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b1.data = tbl[i].d; b1.send_data = 1'b1;
            q1.push_back(tbl[i].d);
            @(negedge clk);
            b1.send_data = 1'b0; b1.data = ~tbl[i].d;
            for (int k = 0; k < 10; k++) begin
                check("u1 Tx bit", b1.Tx, tbl[i].frame[k]);
                check("u1 TiP high", b1.TiP, 1);
                @(negedge clk);
            end
            check("u1 TiP end", b1.TiP, 0);
            check("u1 Tx idle", b1.Tx, 1);
        end

        // send_data held: exactly one idle clock between frames
        @(negedge clk);
        b1.data = 8'h12; b1.send_data = 1'b1;
        q1.push_back(8'h12); q1.push_back(8'h34);
        @(negedge clk);
        b1.data = 8'h34;
        for (int k = 0; k < 10; k++) begin
            check("u1 b2b TiP", b1.TiP, 1);
            @(negedge clk);
        end
        check("u1 b2b gap TiP", b1.TiP, 0);
        check("u1 b2b gap Tx", b1.Tx, 1);
        @(negedge clk);
        check("u1 b2b restart TiP", b1.TiP, 1);
        check("u1 b2b restart Tx", b1.Tx, 0);
        b1.send_data = 1'b0;

        // Random traffic through the divider-1 loopback
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int t = 0; t < 20 && b1.TiP; t++) @(negedge clk);
            check("u1 TiP timeout", b1.TiP, 0);
            d = 8'($urandom);
            q1.push_back(d);
            b1.data = d; b1.send_data = 1'b1;
            @(negedge clk);
            b1.send_data = 1'b0;
        end
        for (int t = 0; t < 100 && q1.size() != 0; t++) @(negedge clk);
        check("u1 drain", q1.size(), 0);

        // Divider 4: data change and extra request during the frame
        @(negedge clk);
        b4.data = 8'hA3; b4.send_data = 1'b1;
        q4.push_back(8'hA3);
        f = {1'b1, 8'hA3, 1'b0};
        @(negedge clk);
        b4.send_data = 1'b0;
        tip_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            check("u4 Tx bit", b4.Tx, f[c/4]);
            if (b4.TiP) tip_cnt++;
            if (c == 5) begin b4.data = 8'hFF; b4.send_data = 1'b1; end
            if (c == 6) b4.send_data = 1'b0;
            @(negedge clk);
        end
        check("u4 TiP cycles", tip_cnt, 40);
        check("u4 TiP end", b4.TiP, 0);
        repeat (8) @(negedge clk);
        check("u4 no extra frame", b4.TiP, 0);
        for (int t = 0; t < 100 && q4.size() != 0; t++) @(negedge clk);
        check("u4 drain A3", q4.size(), 0);

        for (int i = 0; i < 8; i++) begin
            for (int t = 0; t < 60 && b4.TiP; t++) @(negedge clk);
            d = 8'($urandom);
            q4.push_back(d);
            b4.data = d; b4.send_data = 1'b1;
            @(negedge clk);
            b4.send_data = 1'b0;
        end
        for (int t = 0; t < 200 && q4.size() != 0; t++) @(negedge clk);
        check("u4 drain rand", q4.size(), 0);
        repeat (10) @(negedge clk);

        // Loopback 0xC6 with ctrl observation
        b4.data = 8'hC6; b4.send_data = 1'b1;
        q4.push_back(8'hC6);
        @(negedge clk);
        b4.send_data = 1'b0;
        got = 0; seen = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            if (b4.ctrl) seen = 1;
            if (b4.NrD) begin
                got = 1;
                check("u4 loop O_DATA", b4.O_DATA, 8'hC6);
                check("u4 loop ctrl low", b4.ctrl, 0);
            end
            @(negedge clk);
        end
        check("u4 loop NrD seen", got, 1);
        check("u4 loop ctrl seen", seen, 1);
        check("u4 NrD one cycle", b4.NrD, 0);

        // Divider 8: glitch, valid frame, framing error, recovery
        repeat (4) @(negedge clk);
        base = nrd8;
        b8.Rx = 1'b0;
        repeat (2) @(negedge clk);
        b8.Rx = 1'b1;
        repeat (2) @(negedge clk);
        check("u8 glitch ctrl up", b8.ctrl, 1);
        repeat (8) @(negedge clk);
        check("u8 glitch ctrl down", b8.ctrl, 0);
        check("u8 glitch no NrD", nrd8, base);

        drive8(8'h81, 1'b1);
        b8.Rx = 1'b1;
        repeat (10) @(negedge clk);
        check("u8 81 NrD", nrd8, base + 1);
        check("u8 81 O_DATA", b8.O_DATA, 8'h81);
        check("u8 81 ctrl", b8.ctrl, 0);

        base = nrd8;
        drive8(8'h3C, 1'b0);
        repeat (16) @(negedge clk);
        check("u8 ferr ctrl held", b8.ctrl, 1);
        check("u8 ferr no NrD", nrd8, base);
        check("u8 ferr O_DATA", b8.O_DATA, 8'h81);
        b8.Rx = 1'b1;
        repeat (5) @(negedge clk);
        check("u8 ferr ctrl released", b8.ctrl, 0);

        drive8(8'h5A, 1'b1);
        b8.Rx = 1'b1;
        repeat (10) @(negedge clk);
        check("u8 5A NrD", nrd8, base + 1);
        check("u8 5A O_DATA", b8.O_DATA, 8'h5A);

        // Asynchronous reset in the middle of a u4 frame
        b4.data = 8'h99; b4.send_data = 1'b1;
        @(negedge clk);
        b4.send_data = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset TiP", b4.TiP, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst Tx", b4.Tx, 1);
        check("async rst TiP", b4.TiP, 0);
        check("async rst NrD", b4.NrD, 0);
        check("async rst O_DATA", b4.O_DATA, 0);
        check("async rst ctrl", b4.ctrl, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("u4 queue empty", q4.size(), 0);
        check("u4 idle after reset", b4.TiP, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart.md
Name:
uart

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing a single clock and one baud divider.
- Sits between byte-oriented logic (e.g. a USB3300 parser) and a serial pin pair.
- TX serialises a byte on a one-cycle request. RX deserialises frames and flags each new byte with a one-cycle strobe.

Parameters:
- BAUD_DIVIDER, default 104, clock cycles per serial bit. Must be ≥1. The value 1 (one bit per clock) is legal and must work.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rx  in  1  serial input, idle high, asynchronous to clk.
- data  in  8  byte to transmit.
- send_data  in  1  transmit request, sampled on clk.
- Tx  out  1  serial output, idle high, registered.
- TiP  out  1  transmission in progress.
- NrD  out  1  new received data strobe, one cycle.
- O_DATA  out  8  last correctly received byte.
- ctrl  out  1  reception in progress (RX busy).

Behaviour:
- Reset (async, rst=1): Tx=1, TiP=0, NrD=0, O_DATA=0x00, ctrl=0. Both state machines go to IDLE and all counters clear. Reset mid-frame aborts the frame immediately; Tx returns high.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIVIDER clocks, so a frame is 10*BAUD_DIVIDER clocks.
- TX states: IDLE, START, DATA, STOP.
- TX request acceptance:
  - At a rising edge with send_data=1 and TiP=0, the transmitter latches data into a shift register.
  - At that same edge it drives Tx=0 and TiP=1.
- TX bit sequence: after BAUD_DIVIDER cycles per bit, Tx presents data[0]..data[7], then 1.
- TX completion: at the edge that ends the stop bit, TiP returns to 0 and Tx stays 1.
- TX request rules:
  - send_data while TiP=1 is ignored.
  - Changes to data after acceptance have no effect.
  - send_data held high starts the next frame at the first edge with TiP=0, i.e. one idle clock minimum between frames.
  - send_data is level-sampled; a one-cycle pulse suffices.
- RX input synchronisation: Rx passes through a 2-FF synchroniser. All RX timing is relative to the synchronised signal.
- RX states: IDLE, START, DATA, STOP, WAIT_IDLE.
- RX start detection:
  - In IDLE, a synchronised 0 enters START and sets ctrl=1.
  - After BAUD_DIVIDER/2 cycles (integer division; 0 when BAUD_DIVIDER=1), the line is checked.
  - If it is back at 1, this is a glitch: return to IDLE with ctrl=0.
- RX data sampling: each data bit is sampled BAUD_DIVIDER cycles after the previous sample point, LSB first, into a shift register.
- RX stop bit sampled as 1:
  - O_DATA is loaded with the byte.
  - NrD=1 for exactly one cycle.
  - ctrl=0 and the receiver returns to IDLE.
- RX stop bit sampled as 0 (framing error):
  - O_DATA is unchanged and there is no NrD.
  - The receiver goes to WAIT_IDLE, keeping ctrl=1, until the synchronised Rx is 1. It then returns to IDLE with ctrl=0.
- O_DATA holds its value between frames.
- TX and RX are fully independent. Simultaneous transmit and receive, including Tx looped back to Rx, must work.
- Counters are sized for BAUD_DIVIDER; there is no wrap-around inside a bit.

Test Plan:
- Reset: assert rst mid-TX-frame → Tx=1, TiP=0, NrD=0, O_DATA=0x00, ctrl=0 immediately (asynchronous).
- TX, BAUD_DIVIDER=1: data=0x55, one-cycle send_data → Tx sequence 0,1,0,1,0,1,0,1,0,1 on consecutive clocks. TiP high for exactly 10 cycles, then Tx=1 idle.
- TX ignore: with BAUD_DIVIDER=4, send 0xA3, change data to 0xFF and pulse send_data during the frame → transmitted bits still encode 0xA3. TiP stays high 40 cycles with no extra frame.
- Loopback: Tx tied to Rx, BAUD_DIVIDER=4, send 0xC6 → one NrD pulse, O_DATA=0xC6, ctrl high during reception.
- RX framing error: drive a frame of 0x3C with the stop bit 0 → no NrD, O_DATA unchanged, ctrl stays 1 until Rx returns high.
- RX glitch: with BAUD_DIVIDER=8, drive a 2-cycle low pulse on Rx → ctrl returns to 0, no NrD; a following valid frame of 0x81 is received correctly.
